// File: rtl/handshake_pkg.sv
// handshake_pkg: shared types and constants for the handshake bridge.
//   state_e     - output-channel FSM states (IDLE, REQ, REL)
//   DEF_WIDTH   - default data width
//   DEF_DEPTH   - default FIFO depth (power of 2, >= 2)
//   clog2()     - ceiling log2, usable in parameter/port expressions
package handshake_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_REL  = 2'd2
   } state_e;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_DEPTH = 4;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/handshake_fifo.sv
// handshake_fifo: synchronous FIFO, DEPTH entries of WIDTH bits.
//   clk, rst      - clock, synchronous active-low reset
//   push, wr_data - write a word (caller guarantees not full)
//   pop, rd_data  - rd_data shows the head; pop advances it (caller guarantees not empty)
//   full, empty   - occupancy flags
//   count         - current occupancy (0..DEPTH)
//   count_next    - occupancy after this edge's push/pop
module handshake_fifo
   import handshake_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wr_data,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [clog2(DEPTH):0]    count,
   output logic [clog2(DEPTH):0]    count_next
);

   localparam int AW = clog2(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;

   // Pointers wrap naturally because DEPTH is a power of 2.
   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop)      count_d = count_q + CNT_ONE;
      else if (pop && !push) count_d = count_q - CNT_ONE;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; occupancy tracking alone defines validity.
   always_ff @(posedge clk) begin
      if (rst && push) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data    = mem_q[rd_ptr_q];
   assign full       = (count_q == CNT_FULL);
   assign empty      = (count_q == '0);
   assign count      = count_q;
   assign count_next = count_d;

endmodule

// File: rtl/handshake_bridge.sv
// handshake_bridge: rdy/en upstream consumer -> FIFO -> 4-phase en/ack downstream producer.
//   clk, rst          - clock, synchronous active-low reset
//   up_data, up_en    - upstream word and its one-cycle valid
//   up_rdy            - registered: space remains after this edge
//   dn_data, dn_en    - downstream holding register and 4-phase request
//   dn_ack            - downstream 4-phase acknowledge
//   count             - FIFO occupancy (excludes the word in dn_data)
//   drop_err          - sticky: a word arrived while up_rdy was low
module handshake_bridge
   import handshake_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         up_data,
   input  logic                     up_en,
   output logic                     up_rdy,
   output logic [WIDTH-1:0]         dn_data,
   output logic                     dn_en,
   input  logic                     dn_ack,
   output logic [clog2(DEPTH):0]    count,
   output logic                     drop_err
);

   localparam int AW = clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] dn_data_q, dn_data_d;
   logic             up_rdy_q, up_rdy_d;
   logic             drop_err_q, drop_err_d;

   logic             push, pop;
   logic [WIDTH-1:0] fifo_head;
   logic             fifo_full, fifo_empty;
   logic [AW:0]      fifo_count, fifo_count_next;

   // up_rdy already reflects occupancy; the full guard just keeps the FIFO safe.
   assign push = up_en & up_rdy_q & ~fifo_full;

   handshake_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .pop        (pop),
      .wr_data    (up_data),
      .rd_data    (fifo_head),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .count      (fifo_count),
      .count_next (fifo_count_next)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (!fifo_empty) state_d = ST_REQ;
         ST_REQ:  if (dn_ack)      state_d = ST_REL;
         ST_REL:  if (!dn_ack)     state_d = fifo_empty ? ST_IDLE : ST_REQ;
         default:                  state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: pop coincides with loading the holding register.
   always_comb begin
      pop   = 1'b0;
      dn_en = (state_q == ST_REQ);
      case (state_q)
         ST_IDLE: pop = !fifo_empty;
         ST_REL:  pop = !dn_ack && !fifo_empty;
         default: pop = 1'b0;
      endcase
   end

   always_comb begin
      dn_data_d  = pop ? fifo_head : dn_data_q;
      up_rdy_d   = (fifo_count_next < CNT_FULL);
      drop_err_d = drop_err_q | (up_en & ~up_rdy_q);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         dn_data_q  <= '0;
         up_rdy_q   <= 1'b0;
         drop_err_q <= 1'b0;
      end else begin
         dn_data_q  <= dn_data_d;
         up_rdy_q   <= up_rdy_d;
         drop_err_q <= drop_err_d;
      end
   end

   assign dn_data  = dn_data_q;
   assign up_rdy   = up_rdy_q;
   assign count    = fifo_count;
   assign drop_err = drop_err_q;

endmodule

// File: tb/tb_handshake_bridge.sv
module tb_handshake_bridge;

   localparam int WIDTH = 32;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] up_data;
   logic             up_en;
   logic             up_rdy;
   logic [WIDTH-1:0] dn_data;
   logic             dn_en;
   logic             dn_ack;
   logic [2:0]       count;
   logic             drop_err;

   handshake_bridge #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .up_data  (up_data),
      .up_en    (up_en),
      .up_rdy   (up_rdy),
      .dn_data  (dn_data),
      .dn_en    (dn_en),
      .dn_ack   (dn_ack),
      .count    (count),
      .drop_err (drop_err)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;
   int delivered = 0;
   logic [WIDTH-1:0] sb[$];

   // 0: dn_ack driven directly by the sequence, 1: echo dn_en, 2: random delay
   int ack_mode = 0;
   int ack_dly  = 0;
   logic prev_en = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // ack responder, driven away from the active edge
   always @(negedge clk) begin
      if (ack_mode == 1) begin
         dn_ack = dn_en;
      end else if (ack_mode == 2) begin
         if (ack_dly > 0) ack_dly--;
         else if (dn_en && !dn_ack) begin
            dn_ack = 1'b1;
            ack_dly = $urandom_range(0, 3);
         end else if (!dn_en && dn_ack) begin
            dn_ack = 1'b0;
            ack_dly = $urandom_range(0, 3);
         end
      end
   end

   // scoreboard monitor: every new request must carry the next expected word
   always @(negedge clk) begin
      if (dn_en && !prev_en) begin
         if (sb.size() == 0) check("unexpected_word", 64'(dn_data), 64'hDEAD_0000_0000);
         else check("dn_data_order", 64'(dn_data), 64'(sb.pop_front()));
         delivered++;
      end
      prev_en = dn_en;
   end

   task automatic push_word(input logic [WIDTH-1:0] d, input bit accept);
      @(negedge clk);
      up_en   = 1'b1;
      up_data = d;
      if (accept) sb.push_back(d);
      @(posedge clk);
      #1 up_en = 1'b0;
   endtask

   task automatic push_when_ready(input logic [WIDTH-1:0] d);
      int k;
      @(negedge clk);
      for (k = 0; k < 200 && !up_rdy; k++) @(negedge clk);
      if (k == 200) check("up_rdy_timeout", 64'(up_rdy), 64'd1);
      up_en   = 1'b1;
      up_data = d;
      sb.push_back(d);
      @(posedge clk);
      #1 up_en = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 400 && sb.size() != 0; k++) @(negedge clk);
      repeat (8) @(negedge clk);
      check(tag, 64'(sb.size()), 64'd0);
      check({tag, "_count"}, 64'(count), 64'd0);
      check({tag, "_dn_en"}, 64'(dn_en), 64'd0);
   endtask

   initial begin
      int d0;
      // reset held with activity on both sides
      rst = 1'b0; up_en = 1'b1; up_data = 32'h55; dn_ack = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_up_rdy",   64'(up_rdy),   64'd0);
      check("rst_dn_en",    64'(dn_en),    64'd0);
      check("rst_dn_data",  64'(dn_data),  64'd0);
      check("rst_count",    64'(count),    64'd0);
      check("rst_drop_err", 64'(drop_err), 64'd0);
      up_en = 1'b0; dn_ack = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      check("rel_up_rdy", 64'(up_rdy), 64'd1);

      // single word with 1-cycle responder
      ack_mode = 1;
      push_word(32'd123, 1'b1);
      check("single_count_after_push", 64'(count), 64'd1);
      @(posedge clk); #1;
      check("single_dn_en",   64'(dn_en),   64'd1);
      check("single_dn_data", 64'(dn_data), 64'd123);
      check("single_count",   64'(count),   64'd0);
      drain("single_drain");
      check("single_data_kept", 64'(dn_data), 64'd123);

      // fill with ack held low
      ack_mode = 0; dn_ack = 1'b0;
      for (int i = 1; i <= 5; i++) push_word(WIDTH'(i), 1'b1);
      check("fill_count",   64'(count),   64'd4);
      check("fill_up_rdy",  64'(up_rdy),  64'd0);
      check("fill_dn_en",   64'(dn_en),   64'd1);
      check("fill_dn_data", 64'(dn_data), 64'd1);
      push_word(32'd6, 1'b0);
      check("fill_drop_err", 64'(drop_err), 64'd1);
      check("fill_count_drop", 64'(count), 64'd4);
      ack_mode = 1;
      drain("fill_drain");
      check("fill_drop_sticky", 64'(drop_err), 64'd1);

      // simultaneous push and pop on the REL->REQ load edge
      ack_mode = 0; dn_ack = 1'b0;
      push_word(32'hA1, 1'b1);
      push_word(32'hA2, 1'b1);
      push_word(32'hA3, 1'b1);
      check("sim_count_pre", 64'(count), 64'd2);
      @(negedge clk); dn_ack = 1'b1;
      @(posedge clk); #1;
      check("sim_release", 64'(dn_en), 64'd0);
      @(negedge clk); dn_ack = 1'b0;
      up_en = 1'b1; up_data = 32'hA4; sb.push_back(32'hA4);
      @(posedge clk); #1 up_en = 1'b0;
      check("sim_count",   64'(count),   64'd2);
      check("sim_dn_data", 64'(dn_data), 64'hA2);
      ack_mode = 1;
      drain("sim_drain");

      // reset while in REQ with three words queued
      ack_mode = 0; dn_ack = 1'b0;
      for (int i = 0; i < 4; i++) push_word(WIDTH'(32'hB0 + i), 1'b1);
      check("mid_count_pre", 64'(count), 64'd3);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      check("mid_dn_en",    64'(dn_en),    64'd0);
      check("mid_count",    64'(count),    64'd0);
      check("mid_drop_err", 64'(drop_err), 64'd0);
      sb.delete();
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      ack_mode = 1;
      push_word(32'hA5, 1'b1);
      drain("mid_drain");
      check("mid_first_word", 64'(dn_data), 64'hA5);

      // wrap-around stream with random ack delay
      ack_mode = 2; ack_dly = 0;
      d0 = delivered;
      for (int i = 0; i < 20; i++) push_when_ready(WIDTH'(32'h100 + i));
      drain("wrap_drain");
      check("wrap_delivered", 64'(delivered - d0), 64'd20);
      check("wrap_no_drop",   64'(drop_err),       64'd0);
      check("wrap_last",      64'(dn_data),        64'h113);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/handshake_bridge.md
# handshake_bridge

Buffered protocol converter between the two channel styles used around our handshake blocks. Upstream it acts as the consumer of a rdy/en output channel: it drives `up_rdy` and accepts `up_data`/`up_en`. Downstream it acts as the producer of an en/ack input channel: it drives `dn_data`/`dn_en` and waits on `dn_ack`. Words pass through a small synchronous FIFO, so a synthesized `*_out` channel can feed another block's `*_in` channel without loss.

## Interface
Parameters:
- WIDTH, 32: data width.
- DEPTH, 4: FIFO entries. Must be a power of 2 and ≥2. AW = log2(DEPTH).

Ports:
- clk, in, 1: clock. All logic on the rising edge.
- rst, in, 1: reset; synchronous, active-low; clock clk.
- up_data, in, WIDTH: upstream word.
- up_en, in, 1: upstream word valid. One cycle per word.
- up_rdy, out, 1: bridge can accept a word.
- dn_data, out, WIDTH: downstream word.
- dn_en, out, 1: downstream request (4-phase).
- dn_ack, in, 1: downstream acknowledge (4-phase).
- count, out, AW+1: current FIFO occupancy.
- drop_err, out, 1: sticky flag, set when a word arrives while not ready.

## Operation
- Reset (rst=0 at an edge): all outputs are 0 (up_rdy, dn_en, dn_data, count, drop_err). FIFO is emptied and the FSM goes to IDLE. Reset mid-transfer abandons the in-flight word; dn_en is 0 after that edge.
- Upstream accept: a word is written on an edge where up_en=1 and up_rdy=1.
- Upstream drop: up_en=1 with up_rdy=0 writes nothing and sets drop_err=1. drop_err clears only on reset.
- up_rdy is registered: up_rdy = (count_next < DEPTH), where count_next is the occupancy after this edge's push/pop.
- Output stage: one holding register (dn_data), separate from the FIFO. A word is popped from the FIFO when it is loaded into dn_data.
- FSM states IDLE, REQ, REL:
  - IDLE: if FIFO not empty, pop the head into dn_data, set dn_en=1, go to REQ. dn_ack is ignored in IDLE.
  - REQ: dn_en=1 and dn_data held stable. On dn_ack=1, set dn_en=0 and go to REL.
  - REL: wait for dn_ack=0. Then, if FIFO not empty, load the next word, set dn_en=1 and go to REQ; otherwise go to IDLE.
- Push and pop on the same edge: count is unchanged. Pointers wrap modulo DEPTH. count goes 0..DEPTH.
- dn_data keeps its last value after the transfer completes; it is not cleared.

## Timing
- Fall-through latency: word accepted at edge N → FIFO non-empty after N → loaded at edge N+1 → dn_en=1 in the cycle after N+1.
- Ack to release: dn_ack sampled high at edge M → dn_en=0 after M.
- Back-to-back transfers: minimum 4 cycles per word downstream (REQ→ack→REL→ack low→REQ) with a 1-cycle-response peer.
- up_rdy deasserts in the cycle after the edge that fills the FIFO. It reasserts in the cycle after the edge whose pop frees a slot.
- Upstream throughput: one word per cycle while not full.

## Structure
- Package handshake_pkg holds:
  - the FSM state enum (IDLE, REQ, REL);
  - the default WIDTH/DEPTH constants;
  - a clog2-style helper function.
- Sub-module handshake_fifo: synchronous FIFO with push/pop/full/empty/count, parameterized by WIDTH and DEPTH. The top level contains the FSM, the output register, up_rdy and drop_err.

## Test plan
- Reset: hold rst=0 for 3 cycles with up_en=1 and dn_ack=1 → all outputs 0, no write, drop_err=0. After release, up_rdy=1 after the first edge.
- Single word: push 123 at edge N with a 1-cycle ack responder → dn_en=1 with dn_data=123 after N+1, dn_en=0 one edge after ack, count returns to 0.
- Fill/full: dn_ack tied 0, push 1,2,3,4,5 on consecutive cycles (DEPTH=4) → words 1..4 accepted. Word 1 sits in dn_data, so count is 3 and a further push is accepted, then up_rdy=0. A push while up_rdy=0 sets drop_err=1 and that word never appears. Releasing ack delivers the accepted words in order.
- Wrap-around: stream 20 incrementing words with a random-delay ack responder → all 20 delivered in order, no drops, pointers wrap.
- Simultaneous push/pop: with count=2, push on the same edge as the REL→REQ load → count stays 2.
- Reset mid-operation: assert rst while in REQ with count=3 → dn_en=0 and count=0 next cycle. The next pushed word 0xA5 is the first delivered.
